// File: rtl/ch_shot_sequencer_pkg.sv
// Shared types and defaults for the GVIZI shot sequencer.
package gvizi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    CHARGE    = 3'd2,
    RUN       = 3'd3,
    DISCHARGE = 3'd4,
    DONE      = 3'd5
  } seq_state_e;

  localparam int unsigned CHG_CYC_DEF = 8;
  localparam int unsigned HD_CYC_DEF  = 16;
  localparam int unsigned N_CH_MIN    = 2;
  localparam int unsigned N_CH_MAX    = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/ch_shot_sequencer_if.sv
// Host configuration bus for the delay table of the shot sequencer.
interface ch_shot_sequencer_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 16
);
  localparam int unsigned AW = $clog2(N_CH);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;

  modport master (output cfg_we, output cfg_addr, output cfg_data);
  modport slave  (input  cfg_we, input  cfg_addr, input  cfg_data);
endinterface

// File: rtl/ch_shot_sequencer_sync2.sv
// Single-bit two-flop synchronizer for the asynchronous counter fire outputs.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next values of the two synchronizer stages
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // synchronizer stages with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/ch_shot_sequencer.sv
// Per-shot sequencer for the GVIZI delay-channel bank: latches the host delay
// table on trigger and steps through charge, run, discharge and done phases.
module ch_shot_sequencer
  import gvizi_seq_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned CHG_CYC = CHG_CYC_DEF,
  parameter int unsigned HD_CYC  = HD_CYC_DEF,
  parameter int unsigned TMO_W   = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ch_shot_sequencer_if.slave   cfg,
  input  logic [N_CH-1:0]      i_ch_en_mask,
  input  logic                 i_mod,
  input  logic                 i_trig,
  input  logic [N_CH-1:0]      i_ch_out,
  output logic [N_CH*DW-1:0]   o_ch_data,
  output logic [N_CH-1:0]      o_ch_enable,
  output logic                 o_mod,
  output logic                 o_first_charge,
  output logic                 o_start,
  output logic                 o_high_del,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [N_CH-1:0]      o_ch_fired,
  output logic                 o_trig_missed
);
  localparam int unsigned       AW       = $clog2(N_CH);
  localparam int unsigned       PH_W     = $clog2(max_u(CHG_CYC, HD_CYC)) + 1;
  localparam logic [PH_W-1:0]   CHG_LOAD = PH_W'(CHG_CYC - 1);
  localparam logic [PH_W-1:0]   HD_LOAD  = PH_W'(HD_CYC - 1);
  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  seq_state_e          state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d, tmo_inc_s;
  logic                trig_q, trig_d, trig_edge_s;
  logic                start_req_q, start_req_d;
  logic                missed_q, missed_d;
  logic [N_CH-1:0]     ch_sync_s, ch_prev_q, ch_prev_d, ch_rise_s;
  logic [DW-1:0]       table_q [N_CH];
  logic [DW-1:0]       table_d [N_CH];
  logic [N_CH*DW-1:0]  ch_data_q, ch_data_d;
  logic [N_CH-1:0]     ch_en_q, ch_en_d;
  logic                mod_q, mod_d;
  logic [N_CH-1:0]     fired_q, fired_d;
  logic                timeout_q, timeout_d;
  logic                first_charge_q, first_charge_d;
  logic                start_q, start_d;
  logic                high_del_q, high_del_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    sync2 u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_ch_out[g]),
      .o_q     (ch_sync_s[g])
    );
  end

  // trigger edge detection and synchronized fire edge detection
  always_comb begin
    trig_d      = i_trig;
    trig_edge_s = i_trig & ~trig_q;
    ch_prev_d   = ch_sync_s;
    ch_rise_s   = ch_sync_s & ~ch_prev_q;
    if (trig_edge_s && (state_q == IDLE) && (|i_ch_en_mask)) begin
      start_req_d = 1'b1;
    end else begin
      start_req_d = 1'b0;
    end
    if (trig_edge_s && (state_q != IDLE)) begin
      missed_d = 1'b1;
    end else begin
      missed_d = 1'b0;
    end
  end

  // host delay table; addresses with no matching channel fall through unwritten
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      if (cfg.cfg_we && (cfg.cfg_addr == AW'(k))) begin
        table_d[k] = cfg.cfg_data;
      end else begin
        table_d[k] = table_q[k];
      end
    end
  end

  // shot FSM: next state, phase/timeout counters and latched shot context
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tmo_d     = tmo_q;
    ch_data_d = ch_data_q;
    ch_en_d   = ch_en_q;
    mod_d     = mod_q;
    fired_d   = fired_q;
    timeout_d = timeout_q;
    if (tmo_q != TMO_MAX) begin
      tmo_inc_s = tmo_q + TMO_ONE;
    end else begin
      tmo_inc_s = tmo_q;
    end

    case (state_q)
      IDLE: begin
        if (start_req_q) begin
          state_d   = ARM;
          ch_en_d   = i_ch_en_mask;
          mod_d     = i_mod;
          fired_d   = '0;
          timeout_d = 1'b0;
          for (int k = 0; k < N_CH; k++) begin
            ch_data_d[k*DW +: DW] = table_q[k];
          end
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        state_d = CHARGE;
        phase_d = CHG_LOAD;
      end
      CHARGE: begin
        if (phase_q == '0) begin
          state_d = RUN;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      RUN: begin
        // fires landing on the timeout cycle are still recorded
        fired_d = fired_q | ch_rise_s;
        tmo_d   = tmo_inc_s;
        if ((fired_q & ch_en_q) == ch_en_q) begin
          state_d = DISCHARGE;
          phase_d = HD_LOAD;
        end else if (tmo_inc_s == TMO_MAX) begin
          state_d   = DISCHARGE;
          phase_d   = HD_LOAD;
          timeout_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DISCHARGE: begin
        if (phase_q == '0) begin
          state_d = DONE;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // phase strobes are registered from the next state so they align with it
  always_comb begin
    first_charge_d = (state_d == CHARGE);
    start_d        = (state_d == RUN);
    high_del_d     = (state_d == DISCHARGE);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
  end

  // all state and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      tmo_q          <= '0;
      trig_q         <= 1'b0;
      start_req_q    <= 1'b0;
      missed_q       <= 1'b0;
      ch_prev_q      <= '0;
      ch_data_q      <= '0;
      ch_en_q        <= '0;
      mod_q          <= 1'b0;
      fired_q        <= '0;
      timeout_q      <= 1'b0;
      first_charge_q <= 1'b0;
      start_q        <= 1'b0;
      high_del_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        table_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      tmo_q          <= tmo_d;
      trig_q         <= trig_d;
      start_req_q    <= start_req_d;
      missed_q       <= missed_d;
      ch_prev_q      <= ch_prev_d;
      ch_data_q      <= ch_data_d;
      ch_en_q        <= ch_en_d;
      mod_q          <= mod_d;
      fired_q        <= fired_d;
      timeout_q      <= timeout_d;
      first_charge_q <= first_charge_d;
      start_q        <= start_d;
      high_del_q     <= high_del_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      for (int k = 0; k < N_CH; k++) begin
        table_q[k] <= table_d[k];
      end
    end
  end

  assign o_ch_data      = ch_data_q;
  assign o_ch_enable    = ch_en_q;
  assign o_mod          = mod_q;
  assign o_first_charge = first_charge_q;
  assign o_start        = start_q;
  assign o_high_del     = high_del_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_timeout      = timeout_q;
  assign o_ch_fired     = fired_q;
  assign o_trig_missed  = missed_q;
endmodule

// File: tb/tb_ch_shot_sequencer.sv
// Self-checking bench for ch_shot_sequencer: directed shot table, random shots
// against a timeline model, plus mask-zero and mid-shot reset sequences.
module tb_ch_shot_sequencer;
  localparam int RUN_MAX = 63;   // 2^TMO_W - 1 with TMO_W = 6
  localparam int CHG     = 8;
  localparam int HD      = 16;

  typedef struct packed {
    logic [3:0]  mask;
    logic        mod;
    logic [31:0] fire_r;       // byte k: RUN cycle in which ch k rises, 0 = never
    logic        pulse_charge;
    logic        pulse_done;
    logic        write_run;
    int          exp_run;
    logic [3:0]  exp_fired;
    logic        exp_tmo;
    int          exp_missed;
  } shot_vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mask;
  logic        mod;
  logic        trig;
  logic [3:0]  ch_out;
  logic [63:0] o_ch_data;
  logic [3:0]  o_ch_enable, o_ch_fired;
  logic        o_mod, o_first_charge, o_start, o_high_del, o_busy, o_done;
  logic        o_timeout, o_trig_missed;
  logic [15:0] tbl [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ch_shot_sequencer_if #(.N_CH(4), .DW(16)) cfg_bus ();

  ch_shot_sequencer #(
    .N_CH(4), .DW(16), .CHG_CYC(CHG), .HD_CYC(HD), .TMO_W(6)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .cfg            (cfg_bus),
    .i_ch_en_mask   (mask),
    .i_mod          (mod),
    .i_trig         (trig),
    .i_ch_out       (ch_out),
    .o_ch_data      (o_ch_data),
    .o_ch_enable    (o_ch_enable),
    .o_mod          (o_mod),
    .o_first_charge (o_first_charge),
    .o_start        (o_start),
    .o_high_del     (o_high_del),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_timeout      (o_timeout),
    .o_ch_fired     (o_ch_fired),
    .o_trig_missed  (o_trig_missed)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] data);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_addr = 2'(addr);
    cfg_bus.cfg_data = data;
    @(negedge clk);
    cfg_bus.cfg_we   = 1'b0;
    tbl[addr]        = data;
  endtask

  // A rise driven in RUN cycle r is through the 2-flop sync and edge stage by
  // the end of RUN cycle r+2; a complete enabled set ends RUN one cycle later.
  task automatic model_shot(input logic [3:0] m, input logic [31:0] fr,
                            output int run, output logic [3:0] fired, output logic tmo);
    int  last = 0;
    bit  all  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int r = int'(fr[k*8 +: 8]);
      if (m[k]) begin
        if (r == 0) all = 1'b0;
        else if (r > last) last = r;
      end
    end
    if (all && (last + 3 <= RUN_MAX)) begin
      run = last + 3;
      tmo = 1'b0;
    end else begin
      run = RUN_MAX;
      tmo = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      int r = int'(fr[k*8 +: 8]);
      fired[k] = (r != 0) && (r + 2 <= run);
    end
  endtask

  // Runs one shot from the current negedge and checks its whole timeline.
  task automatic run_shot(input int id, input shot_vec_t v);
    logic [63:0] snap;
    int fc_first = -1, st_first = -1, done_idx = -1;
    int fc_len = 0, run_len = 0, hd_len = 0, busy_len = 0, done_cnt = 0, missed = 0;
    snap = {tbl[3], tbl[2], tbl[1], tbl[0]};
    mask = v.mask;
    mod  = v.mod;
    trig = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      trig = 1'b0;
      cfg_bus.cfg_we = 1'b0;
      if (o_first_charge && fc_first < 0) fc_first = i;
      if (o_start && st_first < 0) st_first = i;
      fc_len   += int'(o_first_charge);
      hd_len   += int'(o_high_del);
      busy_len += int'(o_busy);
      missed   += int'(o_trig_missed);
      if (o_start) begin
        run_len++;
        for (int k = 0; k < 4; k++)
          if (int'(v.fire_r[k*8 +: 8]) == run_len) ch_out[k] = 1'b1;
        if (v.write_run && run_len == 2) begin
          cfg_bus.cfg_we   = 1'b1;
          cfg_bus.cfg_addr = 2'd1;
          cfg_bus.cfg_data = 16'd99;
          tbl[1]           = 16'd99;
        end
      end
      if (o_first_charge && fc_len == 3 && v.pulse_charge) trig = 1'b1;
      if (o_done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
        if (v.pulse_done) trig = 1'b1;
      end
      if (done_idx >= 0 && i == done_idx + 2) break;
    end
    check($sformatf("s%0d_fc_latency", id), 64'(fc_first), 64'd3);
    check($sformatf("s%0d_fc_len", id), 64'(fc_len), 64'(CHG));
    check($sformatf("s%0d_start_rise", id), 64'(st_first), 64'(3 + CHG));
    check($sformatf("s%0d_run_len", id), 64'(run_len), 64'(v.exp_run));
    check($sformatf("s%0d_hd_len", id), 64'(hd_len), 64'(HD));
    check($sformatf("s%0d_busy_len", id), 64'(busy_len), 64'(2 + CHG + HD + v.exp_run));
    check($sformatf("s%0d_done_cnt", id), 64'(done_cnt), 64'd1);
    check($sformatf("s%0d_missed", id), 64'(missed), 64'(v.exp_missed));
    check($sformatf("s%0d_data", id), o_ch_data, snap);
    check($sformatf("s%0d_enable", id), 64'(o_ch_enable), 64'(v.mask));
    check($sformatf("s%0d_mod", id), 64'(o_mod), 64'(v.mod));
    check($sformatf("s%0d_fired", id), 64'(o_ch_fired), 64'(v.exp_fired));
    check($sformatf("s%0d_timeout", id), 64'(o_timeout), 64'(v.exp_tmo));
    trig   = 1'b0;
    ch_out = 4'h0;
    repeat (5) @(negedge clk);
  endtask

  shot_vec_t vecs [5];

  initial begin
    shot_vec_t rv;
    int        run, dn, busy_seen;
    logic [3:0] fired;
    logic       tmo;

    //          mask     mod   fire_r (ch3..ch0)   chg   done  wr    run fired   tmo   missed
    vecs[0] = '{4'hF,    1'b0, {8'd40,8'd30,8'd20,8'd10}, 1'b0, 1'b0, 1'b0, 43, 4'hF,   1'b0, 0};
    vecs[1] = '{4'b0101, 1'b1, {8'd0, 8'd0, 8'd0, 8'd61}, 1'b0, 1'b0, 1'b0, 63, 4'b0001, 1'b1, 0};
    vecs[2] = '{4'hF,    1'b0, {8'd3, 8'd3, 8'd3, 8'd3},  1'b1, 1'b1, 1'b0, 6,  4'hF,   1'b0, 2};
    vecs[3] = '{4'b0011, 1'b1, {8'd0, 8'd0, 8'd8, 8'd4},  1'b0, 1'b0, 1'b1, 11, 4'b0011, 1'b0, 0};
    vecs[4] = '{4'b0010, 1'b0, {8'd0, 8'd0, 8'd2, 8'd0},  1'b0, 1'b0, 1'b0, 5,  4'b0010, 1'b0, 0};

    rst_n = 1'b0; trig = 1'b0; mask = 4'h0; mod = 1'b0; ch_out = 4'h0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_data = 16'd0;
    for (int k = 0; k < 4; k++) tbl[k] = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_data", o_ch_data, 64'd0);
    check("reset_ctl", 64'({o_ch_enable, o_mod, o_first_charge, o_start, o_high_del, o_busy,
                            o_done, o_timeout, o_ch_fired, o_trig_missed}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    cfg_write(0, 16'd10);
    cfg_write(1, 16'd20);
    cfg_write(2, 16'd30);
    cfg_write(3, 16'd40);
    for (int v = 0; v < 5; v++) run_shot(v, vecs[v]);
    check("ch1_new_value", 64'(o_ch_data[31:16]), 64'd99);

    for (int s = 0; s < 16; s++) begin
      if ($urandom_range(0, 1) == 1) cfg_write(int'($urandom_range(0, 3)), 16'($urandom));
      rv.mask = 4'($urandom_range(1, 15));
      rv.mod  = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++)
        rv.fire_r[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      rv.pulse_charge = 1'($urandom_range(0, 1));
      rv.pulse_done   = 1'($urandom_range(0, 1));
      rv.write_run    = 1'b0;
      model_shot(rv.mask, rv.fire_r, run, fired, tmo);
      rv.exp_run    = run;
      rv.exp_fired  = fired;
      rv.exp_tmo    = tmo;
      rv.exp_missed = int'(rv.pulse_charge) + int'(rv.pulse_done);
      run_shot(10 + s, rv);
    end

    // trigger with an empty enable mask must be ignored
    mask = 4'h0;
    trig = 1'b1;
    busy_seen = 0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      trig = 1'b0;
      busy_seen += int'(o_busy | o_first_charge | o_trig_missed);
      dn += int'(o_done);
    end
    check("mask0_busy", 64'(busy_seen), 64'd0);
    check("mask0_done", 64'(dn), 64'd0);

    // reset asserted in the middle of RUN aborts the shot silently
    mask = 4'hF;
    trig = 1'b1;
    run = 0;
    for (int i = 0; i < 100 && run < 5; i++) begin
      @(negedge clk);
      trig = 1'b0;
      run += int'(o_start);
    end
    check("rst_reached_run", 64'(run), 64'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_data", o_ch_data, 64'd0);
    check("rst_ctl", 64'({o_ch_enable, o_mod, o_first_charge, o_start, o_high_del, o_busy,
                          o_done, o_timeout, o_ch_fired, o_trig_missed}), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tbl[k] = 16'd0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dn += int'(o_done | o_busy);
    end
    check("rst_no_done", 64'(dn), 64'd0);
    rv = '{4'b1001, 1'b1, {8'd12, 8'd0, 8'd0, 8'd7}, 1'b0, 1'b0, 1'b0, 15, 4'b1001, 1'b0, 0};
    run_shot(99, rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
